// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide unit: single-cycle-issue multiplier and a 32-step restoring divider.
// Optional build macro MULDIV_DIVZERO_FAST_EN: divide-by-zero bypasses the iterative divider.
module muldiv_ctrl #(
  parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ex_stop,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV_RUN, DIV_FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] div_d;
  logic        sgn1;
  logic        sgn2;
  logic        sgn_en;

  logic        op_ok;
  logic        accept;
  logic        move;
  logic        commit_st;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

  assign op_ok     = (req_op != 6'b0) && ((req_op & (req_op - 6'd1)) == 6'b0);
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready & ~flush & ~reset & op_ok;
  assign move      = accept & (req_op[4] | req_op[5]);
  assign commit_st = (state == MUL) || (state == DIV_FIX);
  assign done      = ~reset & ~flush & ~ex_stop & (move | commit_st);

  assign prod_s = $signed({{32{req_src1[31]}}, req_src1}) * $signed({{32{req_src2[31]}}, req_src2});
  assign prod_u = {32'b0, req_src1} * {32'b0, req_src2};

  // Restoring step: the partial remainder never exceeds 2*divisor, so 33 bits suffice.
  assign shifted = {acc_hi, acc_lo[31]};
  assign diff    = shifted - {1'b0, div_d};
  assign qbit    = ~diff[32];

  assign q_fix = (sgn_en && (sgn1 ^ sgn2)) ? neg32(acc_lo) : acc_lo;
  assign r_fix = (sgn_en && sgn1) ? neg32(acc_hi) : acc_hi;

  // Control and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      hi    <= HILO_RESET;
      lo    <= HILO_RESET;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_op[4] && !ex_stop) hi <= req_src1;
            if (req_op[5] && !ex_stop) lo <= req_src1;
            if (req_op[0] || req_op[1]) state <= MUL;
            if (req_op[2] || req_op[3]) begin
              cnt   <= 5'd0;
`ifdef MULDIV_DIVZERO_FAST_EN
              state <= (req_src2 == 32'd0) ? DIV_FIX : DIV_RUN;
`else
              state <= DIV_RUN;
`endif
            end
          end
        end
        MUL: begin
          if (!ex_stop) begin
            hi <= acc_hi;
            lo <= acc_lo;
          end
          state <= IDLE;
        end
        DIV_RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DIV_FIX;
        end
        DIV_FIX: begin
          if (!ex_stop) begin
            hi <= r_fix;
            lo <= q_fix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath working registers
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      if (req_op[0]) {acc_hi, acc_lo} <= prod_s;
      if (req_op[1]) {acc_hi, acc_lo} <= prod_u;
      if (req_op[2] || req_op[3]) begin
        sgn_en <= req_op[2];
        sgn1   <= req_src1[31];
        sgn2   <= req_src2[31];
        acc_hi <= 32'd0;
        acc_lo <= mag32(req_src1, req_op[2]);
        div_d  <= mag32(req_src2, req_op[2]);
`ifdef MULDIV_DIVZERO_FAST_EN
        if (req_src2 == 32'd0) begin
          sgn_en <= 1'b0;
          acc_hi <= req_src1;
          acc_lo <= 32'hFFFF_FFFF;
        end
`endif
      end
    end else if (state == DIV_RUN) begin
      acc_hi <= qbit ? diff[31:0] : shifted[31:0];
      acc_lo <= {acc_lo[30:0], qbit};
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table plus multi-cycle corner sequences.
module tb_muldiv_ctrl;

  localparam logic [31:0] HR = 32'hC0DE_0001;
`ifdef MULDIV_DIVZERO_FAST_EN
  localparam int DZ_LAT = 2;
  localparam logic [31:0] DZS_LO = 32'hFFFF_FFFF;
`else
  localparam int DZ_LAT = 34;
  localparam logic [31:0] DZS_LO = 32'h0000_0001;
`endif

  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b010000;
  localparam logic [5:0] OP_MTLO  = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        ex_stop = 1'b0;
  logic        req_valid = 1'b0;
  logic [5:0]  req_op = 6'b0;
  logic [31:0] req_src1 = 32'b0;
  logic [31:0] req_src2 = 32'b0;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;
  res_t sb[$];

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          lat;
  } vec_t;
  vec_t vecs[15];

  muldiv_ctrl #(.HILO_RESET(HR)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_stop(ex_stop),
    .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .req_ready(req_ready), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one request and follows it until the unit is back in IDLE.
  task automatic do_op(input string nm, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input int es_cyc, input int fl_cyc, input bit commit);
    int got;
    int end_k;
    int bcnt;
    res_t r;
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    if (commit) sb.push_back('{hi: eh, lo: el});
    got = -1; end_k = -1; bcnt = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      ex_stop = (es_cyc == k);
      flush = (fl_cyc == k);
      #1;
      if (busy) bcnt++;
      if (done && got < 0) got = k;
      @(posedge clk);
      #1;
      if (k == 0) begin
        req_valid = 1'b0; req_op = 6'b0; req_src1 = 32'b0; req_src2 = 32'b0;
      end
      if (got == k) begin
        if (sb.size() == 0) begin
          chk({nm, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk({nm, "_hi"}, hi, r.hi);
          chk({nm, "_lo"}, lo, r.lo);
        end
      end
      if (req_ready) begin
        end_k = k;
        break;
      end
    end
    ex_stop = 1'b0;
    flush = 1'b0;
    if (end_k < 0) chk({nm, "_idle_timeout"}, 32'd0, 32'd1);
    if (commit) begin
      chk({nm, "_done_cycle"}, 32'(got), 32'(lat - 1));
      chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(lat - 1));
      cur_hi = eh;
      cur_lo = el;
    end else begin
      chk({nm, "_no_done"}, 32'(got), 32'hFFFF_FFFF);
      chk({nm, "_hi_kept"}, hi, cur_hi);
      chk({nm, "_lo_kept"}, lo, cur_lo);
      if (fl_cyc >= 0) chk({nm, "_flush_idle"}, 32'(end_k), 32'(fl_cyc));
    end
  endtask

  initial begin
    vecs[0]  = '{"mtlo",      OP_MTLO,  32'hA5A5_0001, 32'h0,         HR,            32'hA5A5_0001, 1};
    vecs[1]  = '{"mthi",      OP_MTHI,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'hA5A5_0001, 1};
    vecs[2]  = '{"mult_m1x2", OP_MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[3]  = '{"multu_x2",  OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, 2};
    vecs[4]  = '{"mult_max",  OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 2};
    vecs[5]  = '{"mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2};
    vecs[6]  = '{"divu_100_7",OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34};
    vecs[7]  = '{"div_m7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[8]  = '{"div_7_m2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    vecs[9]  = '{"div_m7_m2", OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         34};
    vecs[10] = '{"divu_max_1",OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 34};
    vecs[11] = '{"div_min_m1",OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
    vecs[12] = '{"divu_5_0",  OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DZ_LAT};
    vecs[13] = '{"div_m5_0",  OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, DZS_LO,        DZ_LAT};
    vecs[14] = '{"divu_hex",  OP_DIVU,  32'h1234_5678, 32'h10,        32'd8,         32'h0123_4567, 34};

    repeat (3) @(negedge clk);
    #1 chk("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, HR);
    chk("reset_lo", lo, HR);
    cur_hi = HR;
    cur_lo = HR;

    for (int i = 0; i < 15; i++)
      do_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].lat, -1, -1, 1'b1);

    // Malformed operation codes must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'b000000; req_src1 = 32'h1111_1111;
    #1 chk("op_zero_done", 32'(done), 32'd0);
    @(negedge clk);
    req_op = 6'b010011;
    #1 chk("op_multi_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("op_multi_ready", 32'(req_ready), 32'd1);
    chk("op_multi_hi", hi, cur_hi);
    chk("op_multi_lo", lo, cur_lo);
    req_valid = 1'b0; req_op = 6'b0;

    do_op("mthi_flushed", OP_MTHI, 32'hBAD0_0001, 32'h0, 32'h0, 32'h0, 1, -1, 0, 1'b0);
    do_op("mthi_exstop",  OP_MTHI, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1, 0, -1, 1'b0);
    do_op("mtlo_55",      OP_MTLO, 32'h0000_0055, 32'h0, cur_hi, 32'h55, 1, -1, -1, 1'b1);
    do_op("mult_exstop",  OP_MULT, 32'd3, 32'd5, 32'h0, 32'h0, 2, 1, -1, 1'b0);
    do_op("divu_flush10", OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 34, -1, 10, 1'b0);
    do_op("divfix_exstop",OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 34, 33, -1, 1'b0);
    do_op("divrun_exstop",OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 5, -1, 1'b1);
    do_op("flush_mul",    OP_MULT, 32'd3, 32'd5, 32'h0, 32'h0, 2, 1, 1, 1'b0);

    // Reset in the middle of a divide abandons it.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_src1 = 32'hFFFF_FFF9; req_src2 = 32'd2;
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = 6'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1 chk("midreset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_ready", 32'(req_ready), 32'd1);
    chk("midreset_hi", hi, HR);
    chk("midreset_lo", lo, HR);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        #1 if (done) seen++;
      end
      chk("midreset_no_done", 32'(seen), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
